// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// ---------------------------------------------------------------------------
// Operand-forwarding and load-use hazard controller for a 5-stage MIPS pipe.
// A shadow scoreboard tracks the destination register of the instructions in
// EXE, MEM and WB. From it the block derives:
//   - the registered EXE-stage operand mux selects (forwardOp1/forwardOp2),
//   - a combinational load-use stall request.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   pipe_en               : global advance enable (0 = everything holds)
//   flush                 : kill the instruction currently in ID
//   id_valid              : ID holds a real instruction
//   id_rs / id_rt         : source register indices of the ID instruction
//   id_uses_rs/id_uses_rt : ID instruction actually reads rs / rt
//   id_dst                : destination register of the ID instruction
//   id_reg_write          : ID instruction writes id_dst
//   id_mem_read           : ID instruction is a load
//   forwardOp1/forwardOp2 : 00 = regfile, 01 = WB data, 10 = EXE/MEM result
//   stall                 : hold PC and IF/ID, bubble into EXE
//
// Optional feature (macro FWD_HAZARD_STATS_EN):
//   stat_stalls, stat_fwd_exe, stat_fwd_wb : 32-bit saturating event counters
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        forwardOp1,
  output logic [1:0]        forwardOp2,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]       stat_stalls,
  output logic [31:0]       stat_fwd_exe,
  output logic [31:0]       stat_fwd_wb,
`endif
  output logic              stall
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_EXE = 2'b10;

  localparam int EXE = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  slot_t       slot_q [3];
  logic [1:0]  fwd1_q, fwd1_d;
  logic [1:0]  fwd2_q, fwd2_d;

  logic        exe_hit_rs_s, exe_hit_rt_s;
  logic        mem_hit_rs_s, mem_hit_rt_s;
  logic        stall_s;
  logic        load_s;

  // A slot produces r when it will write r; $0 is hard-wired and never counts.
  function automatic logic produces(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.dst == r) & (r != {REG_AW{1'b0}});
  endfunction

  // Hazard detection and next forward-select computation for the ID instruction.
  always_comb begin
    exe_hit_rs_s = produces(slot_q[EXE], id_rs);
    exe_hit_rt_s = produces(slot_q[EXE], id_rt);
    mem_hit_rs_s = produces(slot_q[MEM], id_rs);
    mem_hit_rt_s = produces(slot_q[MEM], id_rt);

    // Flush dominates: a killed instruction can never request a stall.
    stall_s = id_valid & ~flush & slot_q[EXE].mem_read &
              ((id_uses_rs & exe_hit_rs_s) | (id_uses_rt & exe_hit_rt_s));
    load_s  = id_valid & ~flush & ~stall_s;

    fwd1_d = FWD_RF;
    fwd2_d = FWD_RF;
    if (load_s && id_uses_rs) begin
      if (exe_hit_rs_s && !slot_q[EXE].mem_read) begin
        fwd1_d = FWD_EXE;
      end else if (mem_hit_rs_s) begin
        fwd1_d = FWD_WB;
      end else begin
        fwd1_d = FWD_RF;
      end
    end else begin
      fwd1_d = FWD_RF;
    end
    if (load_s && id_uses_rt) begin
      if (exe_hit_rt_s && !slot_q[EXE].mem_read) begin
        fwd2_d = FWD_EXE;
      end else if (mem_hit_rt_s) begin
        fwd2_d = FWD_WB;
      end else begin
        fwd2_d = FWD_RF;
      end
    end else begin
      fwd2_d = FWD_RF;
    end
  end

  // Scoreboard shift and registered forward selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        slot_q[i] <= '0;
      end
      fwd1_q <= FWD_RF;
      fwd2_q <= FWD_RF;
    end else if (pipe_en) begin
      // WB keeps no load flag; it is only a landing spot for the MEM occupant.
      slot_q[WB]  <= {slot_q[MEM].valid, slot_q[MEM].dst, slot_q[MEM].reg_write, 1'b0};
      slot_q[MEM] <= slot_q[EXE];
      if (load_s) begin
        slot_q[EXE] <= {1'b1, id_dst, id_reg_write, id_mem_read};
      end else begin
        slot_q[EXE] <= '0;
      end
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign forwardOp1 = fwd1_q;
  assign forwardOp2 = fwd2_q;
  assign stall      = stall_s;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stalls_q, fwd_exe_q, fwd_wb_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != 32'hFFFF_FFFF)) ? (c + 32'd1) : c;
  endfunction

  // Event counters, advanced only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q  <= 32'd0;
      fwd_exe_q <= 32'd0;
      fwd_wb_q  <= 32'd0;
    end else if (pipe_en) begin
      stalls_q  <= sat_inc(stalls_q, stall_s);
      fwd_exe_q <= sat_inc(fwd_exe_q, (fwd1_d == FWD_EXE) || (fwd2_d == FWD_EXE));
      fwd_wb_q  <= sat_inc(fwd_wb_q, (fwd1_d == FWD_WB) || (fwd2_d == FWD_WB));
    end
  end

  assign stat_stalls  = stalls_q;
  assign stat_fwd_exe = fwd_exe_q;
  assign stat_fwd_wb  = fwd_wb_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, randomized
// traffic against a history-based reference model, and a mid-stall reset.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_en, flush, id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [1:0] forwardOp1, forwardOp2;
  logic       stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stat_stalls, stat_fwd_exe, stat_fwd_wb;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forwardOp1(forwardOp1), .forwardOp2(forwardOp2),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stalls(stat_stalls), .stat_fwd_exe(stat_fwd_exe), .stat_fwd_wb(stat_fwd_wb),
`endif
    .stall(stall)
  );

  typedef struct {
    logic en, fl, v;
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] dst;
    logic rw, mr;
    logic [1:0] f1, f2;
    logic st;
  } vec_t;

  function automatic vec_t mk(int en, int fl, int v, int rs, int rt, int urs, int urt,
                              int dst, int rw, int mr, int f1, int f2, int st);
    vec_t x;
    x.en = en[0]; x.fl = fl[0]; x.v = v[0];
    x.rs = rs[4:0]; x.rt = rt[4:0]; x.urs = urs[0]; x.urt = urt[0];
    x.dst = dst[4:0]; x.rw = rw[0]; x.mr = mr[0];
    x.f1 = f1[1:0]; x.f2 = f2[1:0]; x.st = st[0];
    return x;
  endfunction

  // ---------------- reference model: history of EXE entrants ----------------
  typedef struct { logic v; logic [4:0] dst; logic rw; logic mr; } ent_t;
  ent_t hist[$];          // hist[0] = now in EXE, hist[1] = now in MEM
  logic [1:0] mf1, mf2;   // codes presented to the instruction in EXE

  function automatic logic m_prod(int k, logic [4:0] r);
    if (hist.size() <= k) return 1'b0;
    return hist[k].v && hist[k].rw && (hist[k].dst == r) && (r != 5'd0);
  endfunction

  function automatic logic m_stall();
    if (!id_valid || flush || hist.size() == 0 || !hist[0].mr) return 1'b0;
    return (id_uses_rs && m_prod(0, id_rs)) || (id_uses_rt && m_prod(0, id_rt));
  endfunction

  function automatic logic [1:0] m_code(logic used, logic [4:0] r, logic entered);
    if (!entered || !used) return 2'd0;
    if (m_prod(0, r) && !hist[0].mr) return 2'd2;   // distance 1, ALU result
    if (m_prod(1, r)) return 2'd1;                  // distance 2
    return 2'd0;
  endfunction

  task automatic m_reset();
    hist.delete();
    mf1 = 2'd0;
    mf2 = 2'd0;
  endtask

  task automatic m_advance();
    logic entered;
    ent_t e;
    if (!pipe_en) return;
    entered = id_valid && !flush && !m_stall();
    mf1 = m_code(id_uses_rs, id_rs, entered);
    mf2 = m_code(id_uses_rt, id_rt, entered);
    e.v = entered; e.dst = id_dst; e.rw = id_reg_write; e.mr = id_mem_read;
    hist.push_front(e);
    if (hist.size() > 2) void'(hist.pop_back());
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    pipe_en = x.en; flush = x.fl; id_valid = x.v;
    id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_dst = x.dst; id_reg_write = x.rw; id_mem_read = x.mr;
  endtask

  // One cycle: inputs applied just after posedge, outputs sampled at negedge.
  task automatic run_cycle(vec_t x, bit use_tbl, int idx);
    drive(x);
    @(negedge clk);
    if (use_tbl) begin
      chk("tbl_stall", idx, {31'd0, stall}, {31'd0, x.st});
      chk("tbl_fwd1", idx, {30'd0, forwardOp1}, {30'd0, x.f1});
      chk("tbl_fwd2", idx, {30'd0, forwardOp2}, {30'd0, x.f2});
    end else begin
      chk("rnd_stall", idx, {31'd0, stall}, {31'd0, m_stall()});
      chk("rnd_fwd1", idx, {30'd0, forwardOp1}, {30'd0, mf1});
      chk("rnd_fwd2", idx, {30'd0, forwardOp2}, {30'd0, mf2});
    end
    m_advance();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(1,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
    rst_n = 1'b0;
    // Reset held with live-looking inputs: outputs must stay quiet.
    drive(mk(1,0,1, 3,3, 1,1, 3,1,1, 0,0,0));
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", i, {31'd0, stall}, 32'd0);
      chk("rst_fwd1", i, {30'd0, forwardOp1}, 32'd0);
      chk("rst_fwd2", i, {30'd0, forwardOp2}, 32'd0);
    end
    drive(idle);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //          en fl v  rs rt urs urt dst rw mr  f1 f2 st
    tbl.push_back(idle);                                   // 0 idle
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 3,1,0, 0,0,0));      // 1 add $3,$1,$2
    tbl.push_back(mk(1,0,1, 3,5, 1,1, 4,1,0, 0,0,0));      // 2 sub $4,$3,$5
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 2,0,0));      // 3 sub in EXE
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 3,1,0, 0,0,0));      // 4 add $3
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 0,0,0));      // 5 nop
    tbl.push_back(mk(1,0,1, 7,3, 1,1, 6,1,0, 0,0,0));      // 6 or $6,$7,$3
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 0,1,0));      // 7 or in EXE
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 3,1,0, 0,0,0));      // 8 add $3
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 3,1,0, 0,0,0));      // 9 add $3
    tbl.push_back(mk(1,0,1, 3,3, 1,1, 8,1,0, 0,0,0));      // 10 and $8,$3,$3
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 2,2,0));      // 11 and in EXE
    tbl.push_back(mk(1,0,1, 1,9, 1,0, 9,1,1, 0,0,0));      // 12 lw $9
    tbl.push_back(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,1));     // 13 add $10 stalls
    tbl.push_back(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,0));     // 14 bubble in EXE
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 1,1,0));      // 15 add gets WB data
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 0,1,0, 0,0,0));      // 16 add $0
    tbl.push_back(mk(1,0,1, 0,0, 1,1, 5,0,0, 0,0,0));      // 17 reader of $0
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 0,0,0));      // 18
    tbl.push_back(mk(1,0,1, 1,0, 1,0, 0,1,1, 0,0,0));      // 19 lw $0
    tbl.push_back(mk(1,0,1, 0,0, 1,1, 5,0,0, 0,0,0));      // 20 reader of $0, no stall
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 0,0,0));      // 21
    tbl.push_back(mk(1,0,1, 1,9, 1,0, 9,1,1, 0,0,0));      // 22 lw $9
    tbl.push_back(mk(1,1,1, 9,9, 1,1, 10,1,0, 0,0,0));     // 23 flushed load-use
    tbl.push_back(mk(1,0,1, 10,9, 1,1, 11,1,0, 0,0,0));    // 24 reads $10,$9
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 0,1,0));      // 25 no $10 forward
    tbl.push_back(mk(1,0,1, 1,2, 1,1, 3,1,0, 0,0,0));      // 26 add $3
    tbl.push_back(mk(1,0,1, 3,5, 1,1, 4,1,0, 0,0,0));      // 27 sub $4,$3,$5
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 2,0,0));      // 28 frozen
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 2,0,0));      // 29 frozen
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 2,0,0));      // 30 frozen
    tbl.push_back(mk(1,0,1, 4,0, 1,0, 12,1,0, 2,0,0));     // 31 resume, reads $4
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 2,0,0));      // 32 sub still adjacent
    tbl.push_back(mk(1,0,1, 1,9, 1,0, 9,1,1, 0,0,0));      // 33 lw $9
    tbl.push_back(mk(0,0,1, 9,9, 1,1, 10,1,0, 0,0,1));     // 34 frozen, stall live
    tbl.push_back(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,1));     // 35 stall edge
    tbl.push_back(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,0));     // 36 bubble in EXE
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0, 1,1,0));      // 37 WB data

    foreach (tbl[i]) run_cycle(tbl[i], 1'b1, i);

    // Randomized traffic from a clean state against the reference model.
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      vec_t x;
      x = mk(($urandom_range(0, 9) != 0) ? 1 : 0,
             ($urandom_range(0, 9) == 0) ? 1 : 0,
             ($urandom_range(0, 4) != 0) ? 1 : 0,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             0, 0, 0);
      run_cycle(x, 1'b0, i);
    end

    // Reset asserted while a load-use stall is being requested.
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycle(mk(1,0,1, 1,9, 1,0, 9,1,1, 0,0,0), 1'b0, 1000);
    drive(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,0));
    #2;
    chk("pre_rst_stall", 0, {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_stall", 0, {31'd0, stall}, 32'd0);
    chk("async_rst_fwd1", 0, {30'd0, forwardOp1}, 32'd0);
    chk("async_rst_fwd2", 0, {30'd0, forwardOp2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // The discarded load must not stall or forward to the same consumer.
    run_cycle(mk(1,0,1, 9,9, 1,1, 10,1,0, 0,0,0), 1'b0, 1001);
    run_cycle(idle, 1'b0, 1002);
    chk("post_rst_fwd1", 0, {30'd0, forwardOp1}, {30'd0, mf1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Operand-forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It keeps a shadow scoreboard of destination registers for the instructions in EXE, MEM and WB. From that it produces the registered 2-bit `forwardOp1`/`forwardOp2` select codes consumed by the EXE-stage operand muxes, plus a combinational `stall` for load-use hazards. It sits beside the ID/EXE pipeline register and is the producer side of the forwarding-select interface.

## Interface
Parameters:
- `REG_AW`, default 5: register-index width.

Ports (clock and reset first):
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pipe_en` input 1: global advance enable; when 0, all state holds.
- `flush` input 1: kill the instruction currently in ID (taken branch/jump).
- `id_valid` input 1: ID holds a real instruction.
- `id_rs` input REG_AW: source register 1 of the ID instruction.
- `id_rt` input REG_AW: source register 2 of the ID instruction.
- `id_uses_rs` input 1: the ID instruction reads rs.
- `id_uses_rt` input 1: the ID instruction reads rt.
- `id_dst` input REG_AW: destination register of the ID instruction.
- `id_reg_write` input 1: the ID instruction writes `id_dst`.
- `id_mem_read` input 1: the ID instruction is a load.
- `forwardOp1` output 2: select for operand 1 of the instruction now in EXE.
- `forwardOp2` output 2: select for operand 2 of the instruction now in EXE.
- `stall` output 1: hold PC and IF/ID; insert a bubble into EXE.

## Operation
- Select encoding: 00 = register-file value from ID/EXE, 01 = WB data, 10 = EXE/MEM result. Code 11 is never driven.
- Shadow slots: EXE, MEM and WB. Each slot holds {valid, dst, reg_write, mem_read}; WB holds no mem_read.
- A slot "produces" register r when it is valid, has reg_write=1, dst==r and r!=0. Register $0 is never forwarded and never stalls.
- `stall` (combinational) = id_valid & !flush & EXE slot valid & EXE mem_read & EXE reg_write & EXE dst!=0 & ((id_uses_rs & dst==id_rs) | (id_uses_rt & dst==id_rt)).
- On each rising edge with pipe_en=1:
  - The slots shift: EXE→MEM and MEM→WB.
  - The EXE slot loads the ID instruction if id_valid & !flush & !stall; otherwise it loads a bubble (valid=0).
  - forwardOpN for the ID instruction is computed against the pre-shift slots:
    - 10 if the EXE slot produces the source and is not a load;
    - else 01 if the MEM slot produces it;
    - else 00.
    - The EXE slot takes priority over the MEM slot.
  - A bubble or an unused source yields 00.
- With pipe_en=0, slots and outputs hold. `stall` still evaluates combinationally.
- When flush and stall conditions coincide, flush wins: stall=0 and a bubble enters EXE.

## Timing
- Reset (async, rst_n=0): all slots are invalid, forwardOp1=forwardOp2=00, stall=0. Outputs change immediately on reset assertion, not at a clock edge.
- Forward codes are registered with one-cycle latency. They are computed while the instruction is in ID and are valid for the whole cycle that instruction occupies EXE.
- Load-use penalty is exactly one stall cycle. After the bubble, the load is in MEM, so the consumer receives 01 (WB data) when it enters EXE.
- Reset mid-stall: stall drops immediately and all in-flight slots are discarded.

## Configuration
- `FWD_HAZARD_STATS_EN` defined:
  - adds 32-bit saturating output counters `stat_stalls`, `stat_fwd_exe` and `stat_fwd_wb`;
  - each counts edges with pipe_en=1 at which, respectively, a stall bubble entered EXE, any operand got code 10, or any operand got code 01;
  - all counters reset to 0 on rst_n.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Test plan
- Reset held, then released with no instructions → forwardOp1=forwardOp2=00, stall=0 every cycle.
- Back-to-back ALU dependency: `add $3,$1,$2` then `sub $4,$3,$5` → in the sub's EXE cycle, forwardOp1=10 and forwardOp2=00.
- Distance-2 dependency, where rt is the source (`add $3` / `nop` / `or $6,$7,$3`) → forwardOp2=01.
- Same register produced at distances 1 and 2 (`add $3`, `add $3`, `and $8,$3,$3`) → forwardOp1=forwardOp2=10.
- Load-use: `lw $9,0($1)` then `add $10,$9,$9`:
  - stall=1 for exactly one cycle;
  - a bubble enters EXE;
  - the add then enters EXE with forwardOp1=forwardOp2=01.
- Boundary cases:
  - a writer to $0 followed by a reader of $0 → 00 and no stall;
  - flush coinciding with a load-use condition → stall=0 and a bubble enters EXE;
  - pipe_en=0 for 3 cycles mid-sequence → outputs frozen, then resume correctly.
